// File: rtl/slon5_stim_gen_pkg.sv
// Shared types and helpers for the slon5 multi-lane stimulus generator.
package slon5_stim_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK1 = 2'd3
  } StimMode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } StimState_t;

  // Widest lane supported by lfsr_step; narrower lanes zero-extend in and truncate out.
  localparam int unsigned LANE_W_MAX = 64;

  typedef logic [LANE_W_MAX-1:0] lane_word_t;

  function automatic lane_word_t lfsr_step(input lane_word_t v, input lane_word_t poly);
    lane_word_t r;
    r = v >> 1;
    if (v[0]) r = r ^ poly;
    return r;
  endfunction

endpackage

// File: rtl/slon5_stim_gen_if.sv
// Valid/ready beat stream carrying CH_NUM lane words per beat.
interface slon5_stim_gen_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned CH_NUM = 4
);
  logic                           out_valid;
  logic                           out_ready;
  logic [CH_NUM-1:0][WIDTH-1:0]   out_data;
  logic                           out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/slon5_stim_gen_lane.sv
// One stimulus lane: loads its start value from seed/index and advances on accept.
module slon5_stim_lane
  import slon5_stim_pkg::*;
#(
  parameter int unsigned      WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = 32'h8020_0003
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  StimMode_t        mode,
  input  logic [WIDTH-1:0] seed,
  input  logic [31:0]      idx,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] lfsr_init;

  always_comb begin
    lfsr_init = seed ^ WIDTH'(idx);
    // An all-zero LFSR state would lock up, so it is replaced by 1.
    if (lfsr_init == '0) lfsr_init = WIDTH'(1);
    init_val = seed;
    case (mode)
      MODE_COUNT: init_val = seed + WIDTH'(idx);
      MODE_LFSR:  init_val = lfsr_init;
      MODE_CONST: init_val = seed;
      MODE_WALK1: init_val = WIDTH'(1) << (idx % 32'(WIDTH));
      default:    init_val = seed;
    endcase
  end

  always_comb begin
    next_val = q;
    case (mode)
      MODE_COUNT: next_val = q + WIDTH'(1);
      MODE_LFSR:  next_val = WIDTH'(lfsr_step(lane_word_t'(q), lane_word_t'(POLY)));
      MODE_CONST: next_val = q;
      MODE_WALK1: next_val = {q[WIDTH-2:0], q[WIDTH-1]};
      default:    next_val = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= init_val;
    else if (adv)  q <= next_val;
  end

endmodule

// File: rtl/slon5_stim_gen.sv
// Multi-lane burst stimulus source: FSM, beat counter and registered stream flags.
module slon5_stim_gen
  import slon5_stim_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter int unsigned      CH_NUM = 4,
  parameter int unsigned      LEN_W  = 16,
  parameter logic [WIDTH-1:0] POLY   = 32'h8020_0003
) (
  input  logic              clk,
  input  logic              rst,
  input  StimMode_t         cfg_mode,
  input  logic [WIDTH-1:0]  cfg_seed,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              start,
  input  logic              abort,
  slon5_stim_gen_if.master  out_if,
  output logic              busy,
  output logic              done
);

  StimState_t                   state;
  StimMode_t                    mode_q;
  logic [LEN_W-1:0]             len_q;
  logic [LEN_W-1:0]             cnt;
  logic                         valid_q;
  logic                         last_q;
  logic [CH_NUM-1:0][WIDTH-1:0] lane_q;

  logic      accept;
  logic      lane_load;
  logic      lane_adv;
  StimMode_t lane_mode;

  assign accept    = valid_q & out_if.out_ready;
  assign lane_load = (state == ST_IDLE) & start;
  assign lane_adv  = (state == ST_RUN) & accept & ~abort;
  // Lanes see the live config while loading and the latched mode afterwards.
  assign lane_mode = (state == ST_IDLE) ? cfg_mode : mode_q;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_lane
    slon5_stim_lane #(
      .WIDTH (WIDTH),
      .POLY  (POLY)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (lane_load),
      .adv  (lane_adv),
      .mode (lane_mode),
      .seed (cfg_seed),
      .idx  (32'(gi)),
      .q    (lane_q[gi])
    );
  end

  assign out_if.out_data  = lane_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_COUNT;
      len_q   <= '0;
      cnt     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q  <= cfg_mode;
            len_q   <= cfg_len;
            cnt     <= '0;
            valid_q <= 1'b1;
            last_q  <= (cfg_len == LEN_W'(1));
            busy    <= 1'b1;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end else if (accept) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              cnt    <= cnt + LEN_W'(1);
              // Look ahead one beat so out_last is registered with its beat.
              last_q <= (len_q != '0) && ((cnt + LEN_W'(1)) == (len_q - LEN_W'(1)));
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slon5_stim_gen.sv
// Directed self-checking bench for slon5_stim_gen with hand-computed beat values.
module tb_slon5_stim_gen;
  import slon5_stim_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  StimMode_t   cfg_mode;
  logic [31:0] cfg_seed;
  logic [15:0] cfg_len;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  slon5_stim_gen_if #(.WIDTH(32), .CH_NUM(4)) sif ();

  slon5_stim_gen #(
    .WIDTH  (32),
    .CH_NUM (4),
    .LEN_W  (16),
    .POLY   (32'h8020_0003)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .cfg_seed (cfg_seed),
    .cfg_len  (cfg_len),
    .start    (start),
    .abort    (abort),
    .out_if   (sif),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start; returns at the negedge where beat 0 is visible.
  task automatic do_start(input StimMode_t m, input logic [31:0] s, input logic [15:0] l);
    @(negedge clk);
    cfg_mode = m;
    cfg_seed = s;
    cfg_len  = l;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; sif.out_ready = 1'b1;
    cfg_mode = MODE_COUNT; cfg_seed = '0; cfg_len = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b want=0000", {sif.out_valid, sif.out_last, busy, done});
    end
    checks++;
    if (sif.out_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h want=0", sif.out_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_count();
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'd5, 16'd3);
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (sif.out_data[i] !== 32'(5 + b + i)) begin
          failures++;
          $display("FAIL count_data beat=%0d lane=%0d got=%0d want=%0d", b, i, sif.out_data[i], 5 + b + i);
        end
      end
      checks++;
      if ({sif.out_valid, sif.out_last, busy} !== {1'b1, (b == 2), 1'b1}) begin
        failures++;
        $display("FAIL count_flags beat=%0d got=%b want=%b", b, {sif.out_valid, sif.out_last, busy}, {1'b1, (b == 2), 1'b1});
      end
      @(negedge clk);
    end
    checks++;
    if ({sif.out_valid, busy, done} !== 3'b011) begin
      failures++;
      $display("FAIL count_done got=%b want=011", {sif.out_valid, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL count_idle got=%b want=00", {busy, done});
    end
  endtask

  task automatic test_count_wrap();
    logic [31:0] exp0 [4];
    logic [31:0] exp1 [4];
    exp0 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
    exp1 = '{32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2};
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'hFFFF_FFFE, 16'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data[i] !== exp0[i]) begin
        failures++;
        $display("FAIL wrap_beat0 lane=%0d got=%h want=%h", i, sif.out_data[i], exp0[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data[i] !== exp1[i]) begin
        failures++;
        $display("FAIL wrap_beat1 lane=%0d got=%h want=%h", i, sif.out_data[i], exp1[i]);
      end
    end
    checks++;
    if (sif.out_last !== 1'b1) begin
      failures++;
      $display("FAIL wrap_last got=%b want=1", sif.out_last);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_lfsr();
    logic [31:0] exp0 [4];
    logic [31:0] exp1 [4];
    exp0 = '{32'h1, 32'h1, 32'h2, 32'h3};
    exp1 = '{32'h8020_0003, 32'h8020_0003, 32'h1, 32'h8020_0002};
    sif.out_ready = 1'b1;
    do_start(MODE_LFSR, 32'h0, 16'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data[i] !== exp0[i]) begin
        failures++;
        $display("FAIL lfsr_beat0 lane=%0d got=%h want=%h", i, sif.out_data[i], exp0[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sif.out_data[i] !== exp1[i]) begin
        failures++;
        $display("FAIL lfsr_beat1 lane=%0d got=%h want=%h", i, sif.out_data[i], exp1[i]);
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic rdy [7];
    int   acc;
    rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    acc = 0;
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'h0, 16'd4);
    for (int c = 0; c < 7; c++) begin
      sif.out_ready = rdy[c];
      checks++;
      if ({sif.out_valid, sif.out_last, sif.out_data[0]} !== {1'b1, (acc == 3), 32'(acc)}) begin
        failures++;
        $display("FAIL bp_beat cycle=%0d got v=%b l=%b d=%0d want v=1 l=%b d=%0d",
                 c, sif.out_valid, sif.out_last, sif.out_data[0], (acc == 3), acc);
      end
      if (rdy[c]) acc++;
      @(negedge clk);
    end
    sif.out_ready = 1'b1;
    checks++;
    if ({sif.out_valid, busy, done} !== 3'b011) begin
      failures++;
      $display("FAIL bp_done got=%b want=011 accepts=%0d", {sif.out_valid, busy, done}, acc);
    end
    @(negedge clk);
  endtask

  task automatic test_walk_abort();
    int seen_done;
    sif.out_ready = 1'b1;
    seen_done = 0;
    do_start(MODE_WALK1, 32'h0, 16'd0);
    for (int k = 0; k <= 40; k++) begin
      checks++;
      if ({sif.out_valid, sif.out_last, sif.out_data[0], sif.out_data[1]} !==
          {1'b1, 1'b0, 32'h1 << (k % 32), 32'h1 << ((k + 1) % 32)}) begin
        failures++;
        $display("FAIL walk_beat k=%0d got v=%b l=%b l0=%h l1=%h want l0=%h l1=%h",
                 k, sif.out_valid, sif.out_last, sif.out_data[0], sif.out_data[1],
                 32'h1 << (k % 32), 32'h1 << ((k + 1) % 32));
      end
      if (done) seen_done++;
      if (k == 40) abort = 1'b1;
      @(negedge clk);
    end
    abort = 1'b0;
    checks++;
    if ({sif.out_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_stop got=%b want=000", {sif.out_valid, busy, done});
    end
    repeat (3) begin
      if (done) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      failures++;
      $display("FAIL abort_no_done got=%0d want=0", seen_done);
    end
  endtask

  task automatic test_start_busy();
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'd100, 16'd3);
    cfg_mode = MODE_CONST; cfg_seed = 32'd0; cfg_len = 16'd1;
    start = 1'b1;
    for (int b = 0; b < 3; b++) begin
      checks++;
      if ({sif.out_last, sif.out_data[0], sif.out_data[3]} !== {(b == 2), 32'(100 + b), 32'(103 + b)}) begin
        failures++;
        $display("FAIL busy_start beat=%0d got l=%b l0=%0d l3=%0d want l=%b l0=%0d l3=%0d",
                 b, sif.out_last, sif.out_data[0], sif.out_data[3], (b == 2), 100 + b, 103 + b);
      end
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL busy_start_done got=%b want=1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'd50, 16'd10);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({sif.out_valid, sif.out_last, busy, done} !== 4'b0000 || sif.out_data !== '0) begin
      failures++;
      $display("FAIL rst_mid got flags=%b data=%h want 0000/0",
               {sif.out_valid, sif.out_last, busy, done}, sif.out_data);
    end
  endtask

  task automatic test_restart();
    sif.out_ready = 1'b1;
    do_start(MODE_COUNT, 32'd20, 16'd1);
    checks++;
    if ({sif.out_valid, sif.out_last, sif.out_data[0], sif.out_data[3]} !== {1'b1, 1'b1, 32'd20, 32'd23}) begin
      failures++;
      $display("FAIL restart_beat0 got v=%b l=%b l0=%0d l3=%0d want 1 1 20 23",
               sif.out_valid, sif.out_last, sif.out_data[0], sif.out_data[3]);
    end
    @(negedge clk);
    checks++;
    if ({sif.out_valid, busy, done} !== 3'b011) begin
      failures++;
      $display("FAIL restart_done got=%b want=011", {sif.out_valid, busy, done});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_count();
    test_count_wrap();
    test_lfsr();
    test_backpressure();
    test_walk_abort();
    test_start_busy();
    test_rst_mid();
    test_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
